alu_seq_unit: RTL

//   Execution stage directly downstream of the 8-register file: consumes its OUT1/OUT2 read

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_shift_add_mul.sv | 38 +++
 rtl/alu_seq_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and defaults for the sequential ALU stage.
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [2:0] OP_FWD   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_SHIFT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // 110/111 are reserved: they complete but never write back
  function automatic logic op_valid(input logic [2:0] op);
    return !(op[2] && op[1]);
  endfunction

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative shift-add multiplier core: load latches operands, each step retires one
// multiplier bit. prod_nxt is the product including the current step.
module alu_shift_add_mul #(
  parameter int WIDTH = 8,
  parameter int PW    = 2 * WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [PW-1:0]    prod_nxt
);

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;

  assign prod_nxt = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= PW'(a);
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      acc    <= prod_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Execution stage behind the register file: single-cycle FWD/ADD/AND/OR, iterative MUL
// and SHIFT, START/BUSY/DONE handshake. Define ALU_CARRY_FLAG_EN to add the CARRY output.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic [2:0]       SELECT,
  input  logic             START,
  output logic [WIDTH-1:0] RESULT,
  output logic             ZERO,
  output logic             BUSY,
  output logic             DONE,
  output logic             WRITE_EN
`ifdef ALU_CARRY_FLAG_EN
  ,
  output logic             CARRY
`endif
);

  // counter must hold WIDTH (MUL iterations) and the largest shift amount
  localparam int CNT_A = $clog2(WIDTH + 1);
  localparam int CNT_W = (SHAMT_W > CNT_A) ? SHAMT_W : CNT_A;
`ifdef ALU_CARRY_FLAG_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   sh_reg, sh_nxt;
  logic               sh_right;
  logic               op_ok;
  logic               accept, last;
  logic [SHAMT_W-1:0] shamt;
  logic [PW-1:0]      mul_nxt;
  logic               res_we;
  logic [WIDTH-1:0]   res_nxt;
`ifdef ALU_CARRY_FLAG_EN
  logic               cry_nxt;
`endif

  assign accept = START && (state == ST_IDLE);
  assign last   = (cnt == CNT_W'(1));
  assign shamt  = DATA2[SHAMT_W-1:0];
  assign sh_nxt = sh_right ? (sh_reg >> 1) : (sh_reg << 1);
  assign ZERO   = (RESULT == '0);

  alu_shift_add_mul #(.WIDTH(WIDTH), .PW(PW)) u_mul (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (accept && (SELECT == OP_MUL)),
    .step     (state == ST_MUL),
    .a        (DATA1),
    .b        (DATA2),
    .prod_nxt (mul_nxt)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (START) begin
          if (SELECT == OP_MUL)                        state_nxt = ST_MUL;
          else if (SELECT == OP_SHIFT && shamt != '0)  state_nxt = ST_SHIFT;
          else                                         state_nxt = ST_DONE;
        end
      end
      ST_MUL, ST_SHIFT: if (last) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY     = 1'b0;
    DONE     = 1'b0;
    WRITE_EN = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_DONE: begin
        BUSY     = 1'b1;
        DONE     = 1'b1;
        WRITE_EN = op_ok;
      end
      default: BUSY = 1'b1;
    endcase
  end

  // result capture: at acceptance for immediate ops, on the last iteration otherwise
  always_comb begin
    res_we  = 1'b0;
    res_nxt = '0;
`ifdef ALU_CARRY_FLAG_EN
    cry_nxt = 1'b0;
`endif
    if (accept) begin
      res_we = !((SELECT == OP_MUL) || (SELECT == OP_SHIFT && shamt != '0));
      case (SELECT)
        OP_FWD: res_nxt = DATA2;
        OP_ADD: begin
`ifdef ALU_CARRY_FLAG_EN
          {cry_nxt, res_nxt} = {1'b0, DATA1} + {1'b0, DATA2};
`else
          res_nxt = DATA1 + DATA2;
`endif
        end
        OP_AND:   res_nxt = DATA1 & DATA2;
        OP_OR:    res_nxt = DATA1 | DATA2;
        OP_SHIFT: res_nxt = DATA1;
        default:  res_nxt = '0;
      endcase
    end else if (state == ST_MUL && last) begin
      res_we  = 1'b1;
      res_nxt = mul_nxt[WIDTH-1:0];
`ifdef ALU_CARRY_FLAG_EN
      cry_nxt = |mul_nxt[PW-1:WIDTH];
`endif
    end else if (state == ST_SHIFT && last) begin
      res_we  = 1'b1;
      res_nxt = sh_nxt;
`ifdef ALU_CARRY_FLAG_EN
      cry_nxt = sh_right ? sh_reg[0] : sh_reg[WIDTH-1];
`endif
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt      <= '0;
      sh_reg   <= '0;
      sh_right <= 1'b0;
      op_ok    <= 1'b0;
    end else if (accept) begin
      cnt      <= (SELECT == OP_MUL) ? CNT_W'(WIDTH) : CNT_W'(shamt);
      sh_reg   <= DATA1;
      sh_right <= DATA2[WIDTH-1];
      op_ok    <= op_valid(SELECT);
    end else if (state == ST_SHIFT) begin
      cnt      <= cnt - CNT_W'(1);
      sh_reg   <= sh_nxt;
    end else if (state == ST_MUL) begin
      cnt      <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      RESULT <= '0;
    else if (res_we) RESULT <= res_nxt;
  end

`ifdef ALU_CARRY_FLAG_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      CARRY <= 1'b0;
    else if (res_we) CARRY <= cry_nxt;
  end
`endif

endmodule
